// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encoding,
// default geometry and address-field width helpers.
package icache_pkg;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_t;

    localparam int unsigned DEFAULT_LINES      = 16;
    localparam int unsigned DEFAULT_LINE_WORDS = 4;

    // Width of the word-in-line field.
    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Width of the line-index field.
    function automatic int unsigned idx_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Width of the tag field for a 32-bit byte address.
    function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned line_words);
        return 32 - 2 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Cache data word array: asynchronous read port, synchronous write port, no reset.
module icache_data_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; hits answer in the strobe cycle,
// misses refill a full line from backing memory while holding the core busy.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = DEFAULT_LINES,
    parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rbusy,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        invalidate,
    output logic [31:0] miss_count
);

    localparam int unsigned OFF  = off_bits(LINE_WORDS);
    localparam int unsigned IDX  = idx_bits(LINES);
    localparam int unsigned TAGW = tag_bits(LINES, LINE_WORDS);
    localparam int unsigned AW   = OFF + IDX;

    logic [OFF-1:0]  word;
    logic [IDX-1:0]  index;
    logic [TAGW-1:0] tag;
    logic [1:0]      unused_addr_bits;

    assign word             = cpu_addr[OFF+1:2];
    assign index            = cpu_addr[OFF+IDX+1:OFF+2];
    assign tag              = cpu_addr[31:OFF+IDX+2];
    assign unused_addr_bits = cpu_addr[1:0];

    icache_state_t   state;
    logic [LINES-1:0] valid;
    logic [TAGW-1:0] tag_ram [LINES];
    logic [TAGW-1:0] rtag;
    logic [IDX-1:0]  rindex;
    logic [OFF-1:0]  cnt;
    logic            inval_pending;

    logic hit;
    logic cpu_ok;
    logic last_word;
    logic ram_we;

    // Lookup; any pending flush forces the access to report busy.
    always_comb begin
        hit       = valid[index] && (tag_ram[index] == tag);
        cpu_ok    = (state == ICACHE_IDLE) && hit && !invalidate && !inval_pending;
        last_word = (cnt == OFF'(LINE_WORDS - 1));
        ram_we    = (state == ICACHE_REFILL) && !mem_rbusy;
    end

    assign cpu_rbusy = rst || (cpu_rstrb && !cpu_ok);

    icache_data_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .AW    (AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({rindex, cnt}),
        .wdata (mem_rdata),
        .raddr ({index, word}),
        .rdata (cpu_rdata)
    );

    // Tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && ram_we && last_word) begin
            tag_ram[rindex] <= rtag;
        end
    end

    // Control FSM with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ICACHE_IDLE;
            valid         <= '0;
            mem_rstrb     <= 1'b0;
            mem_addr      <= '0;
            miss_count    <= '0;
            cnt           <= '0;
            inval_pending <= 1'b0;
            rtag          <= '0;
            rindex        <= '0;
        end else begin
            case (state)
                ICACHE_IDLE: begin
                    if (invalidate || inval_pending) begin
                        valid         <= '0;
                        inval_pending <= 1'b0;
                    end else if (cpu_rstrb && !hit) begin
                        rtag       <= tag;
                        rindex     <= index;
                        cnt        <= '0;
                        miss_count <= miss_count + 32'd1;
                        mem_rstrb  <= 1'b1;
                        mem_addr   <= {tag, index, {OFF{1'b0}}, 2'b00};
                        state      <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    if (invalidate) begin
                        inval_pending <= 1'b1;
                    end
                    if (!mem_rbusy) begin
                        cnt      <= cnt + OFF'(1);
                        mem_addr <= {rtag, rindex, cnt + OFF'(1), 2'b00};
                        if (last_word) begin
                            valid[rindex] <= !inval_pending && !invalidate;
                            mem_rstrb     <= 1'b0;
                            state         <= ICACHE_IDLE;
                        end
                    end
                end
                default: state <= ICACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: backing-memory responder with scoreboarded
// refill addresses and a fetch task checking data, busy length and counters.
module tb_icache;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_rstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_rbusy;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        invalidate;
    logic [31:0] miss_count;

    int n_cmp;
    int n_err;
    logic [31:0] addr_q [$];
    logic [31:0] data_q [$];
    logic        wait_mode;

    icache #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_rstrb  (cpu_rstrb),
        .cpu_rdata  (cpu_rdata),
        .cpu_rbusy  (cpu_rbusy),
        .mem_addr   (mem_addr),
        .mem_rstrb  (mem_rstrb),
        .mem_rdata  (mem_rdata),
        .mem_rbusy  (mem_rbusy),
        .invalidate (invalidate),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Backing memory: optional 2 wait cycles per word, scoreboarded addresses.
    initial begin : responder
        logic        prev_busy;
        logic [31:0] prev_addr;
        logic [31:0] exp;
        int          wcnt;
        prev_busy = 1'b0;
        prev_addr = '0;
        wcnt      = 0;
        mem_rbusy = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_busy && mem_rstrb) check("mem_addr_stable", mem_addr, prev_addr);
            mem_rdata = mem_model(mem_addr);
            if (mem_rstrb && wait_mode && wcnt < 2) begin
                mem_rbusy = 1'b1;
                wcnt++;
            end else begin
                mem_rbusy = 1'b0;
                wcnt = 0;
            end
            if (mem_rstrb && !mem_rbusy) begin
                if (addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL mem_unexpected observed=%h expected=none", mem_addr);
                end else begin
                    exp = addr_q.pop_front();
                    check("mem_addr", mem_addr, exp);
                end
            end
            prev_busy = mem_rstrb && mem_rbusy;
            prev_addr = mem_addr;
        end
    end

    // One fetch; inv_cycle selects the cycle (0 = strobe cycle) to pulse invalidate.
    task automatic fetch(input string tag, input logic [31:0] a, input int exp_busy,
                         input int refills, input int inv_cycle);
        int busy;
        int k;
        logic [31:0] exp;
        for (int r = 0; r < refills; r++)
            for (int w = 0; w < 4; w++)
                addr_q.push_back({a[31:4], 4'h0} + 32'(w * 4));
        data_q.push_back(mem_model({a[31:2], 2'b00}));
        cpu_addr  = a;
        cpu_rstrb = 1'b1;
        busy = 0;
        k    = 0;
        forever begin
            invalidate = (k == inv_cycle);
            @(negedge clk);
            if (!cpu_rbusy) break;
            busy++;
            k++;
            if (k > 200) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s_timeout observed=busy expected=done", tag);
                break;
            end
            @(posedge clk);
            #1;
        end
        exp = data_q.pop_front();
        check({tag, "_rdata"}, cpu_rdata, exp);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        cpu_rstrb  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_cmp      = 0;
        n_err      = 0;
        wait_mode  = 1'b0;
        rst        = 1'b1;
        cpu_addr   = '0;
        cpu_rstrb  = 1'b0;
        invalidate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(cpu_rbusy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_rstrb", 32'(mem_rstrb), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
        check("reset_idle_busy", 32'(cpu_rbusy), 32'd0);

        // Strobe low: nothing happens.
        @(posedge clk);
        #1;
        cpu_addr = 32'h0000_0500;
        repeat (3) begin
            @(negedge clk);
            check("nostrobe_busy", 32'(cpu_rbusy), 32'd0);
            check("nostrobe_mem_rstrb", 32'(mem_rstrb), 32'd0);
        end
        @(posedge clk);
        #1;

        fetch("cold", 32'h0000_0010, 5, 1, -1);
        check("cold_miss_count", miss_count, 32'd1);

        fetch("hit", 32'h0000_0014, 0, 0, -1);
        check("hit_mem_rstrb", 32'(mem_rstrb), 32'd0);
        check("hit_miss_count", miss_count, 32'd1);

        fetch("conflict_a", 32'h0000_0110, 5, 1, -1);
        fetch("conflict_b", 32'h0000_0010, 5, 1, -1);
        check("conflict_miss_count", miss_count, 32'd3);

        wait_mode = 1'b1;
        fetch("waits", 32'h0000_0040, 13, 1, -1);
        wait_mode = 1'b0;
        check("waits_miss_count", miss_count, 32'd4);

        // Invalidate in IDLE with concurrent fetch: flush cycle busy, then miss.
        fetch("inv_idle", 32'h0000_0014, 6, 1, 0);
        check("inv_idle_miss_count", miss_count, 32'd5);

        // Invalidate on 2nd refill word: line left invalid, refetch misses.
        fetch("inv_refill", 32'h0000_0020, 11, 2, 2);
        check("inv_refill_miss_count", miss_count, 32'd7);

        // Reset on the 3rd refill word.
        for (int w = 0; w < 3; w++) addr_q.push_back(32'h0000_0010 + 32'(w * 4));
        cpu_addr  = 32'h0000_0010;
        cpu_rstrb = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(cpu_rbusy), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cpu_rstrb = 1'b0;
        @(negedge clk);
        check("midrst_mem_rstrb", 32'(mem_rstrb), 32'd0);
        check("midrst_miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        fetch("post_rst", 32'h0000_0010, 5, 1, -1);
        check("post_rst_miss_count", miss_count, 32'd1);

        repeat (3) @(posedge clk);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the rv32i fetch port (mem_i_*) and the backing instruction memory.
- Hits return the instruction combinationally in the same cycle as the strobe, so fetch completes without freezing.
- Misses refill a whole line sequentially from backing memory, holding the core frozen via cpu_rbusy.
- Both sides use the core's strobe/busy read protocol.

Parameters:
- LINES, 16, number of cache lines (power of two, >=2).
- LINE_WORDS, 4, 32-bit words per line (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_addr  in  32  fetch address; bits [1:0] ignored
- cpu_rstrb  in  1  fetch request
- cpu_rdata  out  32  instruction; valid when cpu_rstrb && !cpu_rbusy
- cpu_rbusy  out  1  fetch not yet satisfiable
- mem_addr  out  32  backing-memory word address
- mem_rstrb  out  1  backing-memory read request
- mem_rdata  in  32  backing-memory data; valid when mem_rstrb && !mem_rbusy
- mem_rbusy  in  1  backing memory not ready
- invalidate  in  1  one-cycle pulse; flush all lines (fence.i)
- miss_count  out  32  number of refills started, wraps modulo 2^32

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Address split: OFF = log2(LINE_WORDS), IDX = log2(LINES).
  - word = addr[OFF+1:2]
  - index = addr[OFF+IDX+1:OFF+2]
  - tag = addr[31:OFF+IDX+2]
- Storage:
  - Per line: valid bit and tag (registers).
  - Data array: LINES*LINE_WORDS x 32, asynchronous read, synchronous write.
- hit = valid[index] && tag_ram[index] == tag, evaluated in IDLE only.
- cpu_rdata = data[index][word], combinational; it is don't-care when not a hit.
- cpu_rbusy = cpu_rstrb && !(state==IDLE && hit). It is forced to 1 while rst is high.
- Reset:
  - state IDLE, all valid=0, mem_rstrb=0, mem_addr=0, miss_count=0, refill counter=0, inval_pending=0.
  - Reset mid-refill aborts the refill; mem_rstrb is 0 the cycle after rst is sampled.
- FSM state IDLE:
  - If invalidate or inval_pending: clear all valid bits and inval_pending. Remain IDLE. Any access this cycle is reported busy.
  - Else if cpu_rstrb && !hit: latch refill tag/index, set cnt=0, increment miss_count, go to REFILL.
  - Hit with no invalidate: no state change.
- FSM state REFILL:
  - mem_rstrb=1 and mem_addr={rtag, rindex, cnt, 2'b00}, both registered.
  - Each cycle with !mem_rbusy: write mem_rdata into data[rindex][cnt], then cnt++.
  - mem_addr is held stable while mem_rbusy.
  - On the last word (cnt==LINE_WORDS-1 && !mem_rbusy):
    - Write tag_ram[rindex]=rtag.
    - Set valid[rindex]=!inval_pending && !invalidate.
    - Deassert mem_rstrb next cycle and go to IDLE.
- Invalidate during REFILL:
  - Sets inval_pending.
  - The refill completes, but the line is left invalid.
  - All lines are cleared in the following IDLE cycle.
- Latency:
  - Miss detected in cycle T (busy).
  - REFILL occupies T+1..T+LINE_WORDS with a zero-wait memory.
  - Hit in T+LINE_WORDS+1, so cpu_rbusy is high LINE_WORDS+1 cycles.
  - Each memory wait cycle adds one.
- The core holds cpu_addr stable while busy.
  - If cpu_addr changes mid-refill, the refill still completes for the latched line.
  - Hit/miss is then re-evaluated on the new address in IDLE.
- cpu_rstrb low: no refill is started and cpu_rbusy=0.
- miss_count increments in the IDLE->REFILL transition cycle only; it wraps 0xFFFFFFFF->0.

Decomposition:
- Shared package (rv32i.vh style header):
  - ICACHE_IDLE / ICACHE_REFILL state encodings.
  - Default LINES/LINE_WORDS constants.
  - Address-field width macros.
- One sub-module: icache_data_ram. Word array with asynchronous read and synchronous write-enable/write-address; no reset.
- Valid/tag registers and the FSM stay in icache.

Test Plan (LINES=16, LINE_WORDS=4, tag=[31:8], index=[7:4], word=[3:2]):
- Cold miss, zero-wait memory, cpu_addr=0x00000010:
  - mem_addr sequence 0x10, 0x14, 0x18, 0x1C.
  - cpu_rbusy high 5 cycles, then cpu_rdata=mem[0x10].
  - miss_count=1.
- Hit after fill, cpu_addr=0x00000014:
  - cpu_rbusy=0 in the same cycle, cpu_rdata=mem[0x14].
  - mem_rstrb stays 0 and miss_count stays 1.
- Conflict: fetch 0x00000110 (index 1, tag 0x000001), then 0x00000010:
  - Both miss; miss_count=3.
  - The final cpu_rdata=mem[0x10].
- Wait states, mem_rbusy high 2 cycles per word, cold miss at 0x00000040:
  - REFILL lasts 12 cycles and cpu_rbusy is high 13 cycles.
  - mem_addr is stable during each busy window.
- Invalidate:
  - Pulse in IDLE, then fetch 0x00000014: that cycle busy, then a miss.
  - Pulse at the 2nd refill word: refill of 4 words completes, line stays invalid, refetch misses again; 2 misses counted.
- rst asserted at the 3rd refill word:
  - mem_rstrb=0 and miss_count=0 next cycle.
  - After reset, fetch 0x00000010 misses.
